mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter ITER, default 16, iteration cycles per operation (equals WIDTH).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-006 SHALL have port op, input, 1, 0 = signed multiply, 1 = signed divide.
REQ-007 SHALL have port opA, input, 16, multiplicand / dividend.
REQ-008 SHALL have port opB, input, 16, multiplier / divisor.
REQ-009 SHALL have port dstAddr, input, 3, destination register for low word / quotient.
REQ-010 SHALL have port busy, output, 1, high from accept until done cycle inclusive.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port divByZero, output, 1, valid with done; high when divide had opB = 0.
REQ-013 SHALL have ports wr (1), wrR15 (1), wrAddr (3), wrData (16), wrDataR15 (16), outputs, driving the register-file write port directly.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX, WB.
REQ-015 SHALL, in IDLE with start = 1, latch opA, opB, op, dstAddr, and go to MUL (op = 0) or DIV (op = 1).
REQ-016 SHALL ignore start in every state except IDLE; latched operands are unaffected by input changes after accept.
REQ-017 SHALL operate on magnitudes, with one shift-add (MUL) or one restoring-subtract (DIV) step per cycle for ITER cycles, then enter FIX.
REQ-018 SHALL, in FIX, apply the result sign: product negative iff operand signs differ; quotient truncates toward zero; remainder takes the dividend's sign.
REQ-019 SHALL, in WB, assert done = 1 and wr = 1 for exactly one cycle, with wrAddr = dstAddr.
REQ-020 SHALL, in WB, drive wrData = product[15:0] or quotient, and wrDataR15 = product[31:16] or remainder.
REQ-021 SHALL, in WB, assert wrR15 = 1 unless dstAddr = 0, in which case wrR15 = 0 and only the low word is written.
REQ-022 SHALL place done exactly 18 cycles after the accepting edge (16 iterate + FIX + WB), for both ops.
REQ-023 SHALL, for divide with opB = 0, skip DIV and go directly to WB on the next edge with done = 1, divByZero = 1, and wr = wrR15 = 0 (no register update).
REQ-024 SHALL give -32768 / -1 the result quotient 0x8000, remainder 0x0000, divByZero = 0.
REQ-025 SHALL return to IDLE after WB; start may be accepted in the cycle immediately after done.
REQ-026 SHALL hold wr, wrR15, done, and divByZero at 0 in every cycle other than WB.

Reset
REQ-027 SHALL, on rst = 0 at a clock edge, enter IDLE regardless of state, abandoning any operation without a write.
REQ-028 SHALL reset busy, done, divByZero, wr, and wrR15 to 0; wrAddr to 0; wrData and wrDataR15 to 0x0000; all internal accumulators to 0.

Structure
REQ-029 SHALL take the op encodings (OP_MUL, OP_DIV), the state encoding, and WIDTH/ITER defaults from the shared CPU package.
REQ-030 SHALL be a single module with no sub-module; the iteration counter is a 5-bit internal register.

Verification
REQ-031 SHALL cover multiply 0x0003 × 0xFFFB -> after 18 cycles: wrData = 0xFFF1, wrDataR15 = 0xFFFF, wr = wrR15 = 1.
REQ-032 SHALL cover multiply 0x7FFF × 0x7FFF, dstAddr = 0 -> wrData = 0x0001, wrDataR15 = 0x3FFF, wr = 1, wrR15 = 0.
REQ-033 SHALL cover divide 100 / 7 -> quotient 0x000E, remainder 0x0002; and -7 / 2 -> quotient 0xFFFD, remainder 0xFFFF.
REQ-034 SHALL cover divide 0x1234 / 0 -> done 1 cycle after accept, divByZero = 1, wr = wrR15 = 0.
REQ-035 SHALL cover start re-pulsed at cycle 5 with new operands -> ignored; first result unchanged, done still at cycle 18.
REQ-036 SHALL cover rst = 0 at cycle 10 of a divide -> busy = 0 next cycle, no wr pulse ever, next start accepted normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared CPU encodings and defaults for the iterative multiply/divide unit.
package mul_div_unit_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int ITER_DEF  = 16;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        WB   = 3'd4
    } state_t;
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed multiply / restoring divide writing results straight into the register file.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [2:0]       dstAddr,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic             wr,
    output logic             wrR15,
    output logic [2:0]       wrAddr,
    output logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] wrDataR15
);
    state_t           state, next_state;
    op_t              op_q;
    logic [4:0]       cnt;
    logic [2:0]       dst_q;
    logic             sa, sb, dbz;
    logic [WIDTH-1:0] hi, lo, mcand, res_lo, res_hi;
    logic [WIDTH-1:0] a_abs, b_abs, shifted, q_s, r_s;
    logic [WIDTH:0]   sum, diff;
    logic [2*WIDTH-1:0] prod_s;
    logic             accept, fits, last;

    assign accept  = state == IDLE && start;
    assign last    = cnt == 5'(ITER - 1);
    assign a_abs   = opA[WIDTH-1] ? -opA : opA;
    assign b_abs   = opB[WIDTH-1] ? -opB : opB;
    assign sum     = lo[0] ? {1'b0, hi} + {1'b0, mcand} : {1'b0, hi};
    // Partial remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so hi's MSB is always 0 here
    assign shifted = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {1'b0, mcand};
    assign fits    = !diff[WIDTH];
    assign prod_s  = (sa ^ sb) ? -{hi, lo} : {hi, lo};
    assign q_s     = (sa ^ sb) ? -lo : lo;
    assign r_s     = sa ? -hi : hi;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = op == OP_DIV ? (opB == '0 ? WB : DIV) : MUL;
            MUL,
            DIV:     if (last) next_state = FIX;
            FIX:     next_state = WB;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        done      = state == WB;
        divByZero = done && dbz;
        wr        = done && !dbz;
        wrR15     = wr && dst_q != 3'd0;
        wrAddr    = done ? dst_q : 3'd0;
        wrData    = wr ? res_lo : '0;
        wrDataR15 = wr ? res_hi : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q   <= OP_MUL;
            cnt    <= '0;
            dst_q  <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dbz    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            res_lo <= '0;
            res_hi <= '0;
        end else if (accept) begin
            op_q  <= op_t'(op);
            cnt   <= '0;
            dst_q <= dstAddr;
            sa    <= opA[WIDTH-1];
            sb    <= opB[WIDTH-1];
            dbz   <= op == OP_DIV && opB == '0;
            hi    <= '0;
            lo    <= a_abs;
            mcand <= b_abs;
        end else if (state == MUL) begin
            hi  <= sum[WIDTH:1];
            lo  <= {sum[0], lo[WIDTH-1:1]};
            cnt <= cnt + 5'd1;
        end else if (state == DIV) begin
            hi  <= fits ? diff[WIDTH-1:0] : shifted;
            lo  <= {lo[WIDTH-2:0], fits};
            cnt <= cnt + 5'd1;
        end else if (state == FIX) begin
            res_lo <= op_q == OP_MUL ? prod_s[WIDTH-1:0] : q_s;
            res_hi <= op_q == OP_MUL ? prod_s[2*WIDTH-1:WIDTH] : r_s;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for the multiply/divide unit.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] opA = '0, opB = '0;
    logic [2:0]  dstAddr = '0;
    logic        busy, done, divByZero, wr, wrR15;
    logic [2:0]  wrAddr;
    logic [15:0] wrData, wrDataR15;
    int n_asrt = 0, n_fail = 0, stray = 0, lat = 0;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
        .dstAddr(dstAddr), .busy(busy), .done(done), .divByZero(divByZero),
        .wr(wr), .wrR15(wrR15), .wrAddr(wrAddr), .wrData(wrData), .wrDataR15(wrDataR15)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of cycle 1 after the accepting edge
    task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
        @(negedge clk);
        op = o; opA = a; opB = b; dstAddr = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat = 1;
        while (!done && lat < 40) begin
            if (wr || wrR15) stray++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic result(input string tag, input int elat, input logic [15:0] lo, input logic [15:0] hi,
                          input logic ewr, input logic er15, input logic [2:0] ea, input logic edbz);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_wrData"}, wrData, lo);
        chk({tag, "_wrDataR15"}, wrDataR15, hi);
        chk({tag, "_wr"}, wr, ewr);
        chk({tag, "_wrR15"}, wrR15, er15);
        chk({tag, "_wrAddr"}, wrAddr, ea);
        chk({tag, "_divByZero"}, divByZero, edbz);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_clr"}, done, 1'b0);
        chk({tag, "_busy_clr"}, busy, 1'b0);
        chk({tag, "_wr_clr"}, wr, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dbz", divByZero, 1'b0);
        chk("rst_wr", wr, 1'b0);
        chk("rst_wrR15", wrR15, 1'b0);
        chk("rst_wrAddr", wrAddr, 3'd0);
        chk("rst_wrData", wrData, 16'h0000);
        chk("rst_wrDataR15", wrDataR15, 16'h0000);
        rst = 1'b1;

        issue(1'b0, 16'h0003, 16'hFFFB, 3'd5);
        chk("mul1_busy_c1", busy, 1'b1);
        wait_done();
        result("mul1", 18, 16'hFFF1, 16'hFFFF, 1'b1, 1'b1, 3'd5, 1'b0);
        after_done("mul1");

        issue(1'b0, 16'h7FFF, 16'h7FFF, 3'd0);
        wait_done();
        result("mul2", 18, 16'h0001, 16'h3FFF, 1'b1, 1'b0, 3'd0, 1'b0);
        after_done("mul2");

        issue(1'b1, 16'd100, 16'd7, 3'd3);
        wait_done();
        result("div1", 18, 16'h000E, 16'h0002, 1'b1, 1'b1, 3'd3, 1'b0);
        // Back-to-back: start presented in the cycle right after done
        issue(1'b1, 16'hFFF9, 16'd2, 3'd2);
        wait_done();
        result("div2", 18, 16'hFFFD, 16'hFFFF, 1'b1, 1'b1, 3'd2, 1'b0);
        after_done("div2");

        issue(1'b1, 16'h1234, 16'h0000, 3'd4);
        wait_done();
        result("dbz", 1, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd4, 1'b1);
        after_done("dbz");

        issue(1'b1, 16'h8000, 16'hFFFF, 3'd1);
        wait_done();
        result("ovf", 18, 16'h8000, 16'h0000, 1'b1, 1'b1, 3'd1, 1'b0);
        after_done("ovf");

        issue(1'b0, 16'hFFF0, 16'h0020, 3'd6);
        lat = 1;
        while (!done && lat < 40) begin
            if (wr || wrR15) stray++;
            if (lat == 4) begin
                start = 1'b1; op = 1'b1; opA = 16'h0005; opB = 16'h0000; dstAddr = 3'd1;
            end else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        result("repulse", 18, 16'hFE00, 16'hFFFF, 1'b1, 1'b1, 3'd6, 1'b0);
        after_done("repulse");

        issue(1'b1, 16'd1000, 16'd10, 3'd7);
        repeat (9) begin
            if (wr || wrR15 || done) stray++;
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_wr", wr, 1'b0);
        rst = 1'b1;
        repeat (20) begin
            if (wr || wrR15 || done) stray++;
            @(negedge clk);
        end
        issue(1'b1, 16'd1000, 16'd10, 3'd7);
        wait_done();
        result("post_rst", 18, 16'h0064, 16'h0000, 1'b1, 1'b1, 3'd7, 1'b0);
        after_done("post_rst");

        chk("no_stray_wr", stray, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
